// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps a DDS frequency word from f_start toward f_stop,
// holding each word for a programmable dwell, in single, repeat or
// triangle fashion. All outputs come straight from flops.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,      // active-high synchronous reset
  input  logic               start,
  input  logic               abort,
  input  logic [10:0]        f_start,
  input  logic [10:0]        f_stop,
  input  logic [10:0]        f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  output logic [10:0]        freq_out,
  output logic               freq_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // Next word going up: the sum is formed one bit wider so it cannot wrap,
  // then clamped to the upper limit.
  function automatic logic [10:0] step_up(input logic [10:0] cur,
                                          input logic [10:0] step,
                                          input logic [10:0] lim);
    logic [11:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= {1'b0, lim}) begin
      step_up = lim;
    end else begin
      step_up = sum[10:0];
    end
  endfunction

  // Next word going down: clamp to the lower limit before subtracting so
  // the difference can never underflow.
  function automatic logic [10:0] step_down(input logic [10:0] cur,
                                            input logic [10:0] step,
                                            input logic [10:0] lim);
    logic [11:0] floor_plus;
    floor_plus = {1'b0, lim} + {1'b0, step};
    if ({1'b0, cur} <= floor_plus) begin
      step_down = lim;
    end else begin
      step_down = cur - step;
    end
  endfunction

  // Completed-sweep counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      sat_inc = c;
    end else begin
      sat_inc = c + CNT_W'(1);
    end
  endfunction

  // Dwell counter reload: the counter runs D-1 .. 0, a zero dwell acts as 1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] dw);
    if (dw == {DWELL_W{1'b0}}) begin
      dwell_reload = {DWELL_W{1'b0}};
    end else begin
      dwell_reload = dw - DWELL_W'(1);
    end
  endfunction

  state_t             state_q,    state_d;
  logic [10:0]        f_start_q,  f_start_d;
  logic [10:0]        f_stop_q,   f_stop_d;
  logic [10:0]        step_q,     step_d;
  logic [DWELL_W-1:0] reload_q,   reload_d;
  logic [1:0]         mode_q,     mode_d;
  logic               degen_q,    degen_d;
  logic [DWELL_W-1:0] dcnt_q,     dcnt_d;
  logic [10:0]        freq_q,     freq_d;
  logic               valid_q,    valid_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               expire_s;

  assign expire_s = (dcnt_q == {DWELL_W{1'b0}});

  // Sequencer: decide the next state, next word and all next-cycle outputs.
  always_comb begin
    state_d   = state_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    step_d    = step_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    degen_d   = degen_q;
    dcnt_d    = dcnt_q;
    freq_d    = freq_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          // Capture the whole configuration; later input changes are ignored.
          f_start_d = f_start;
          f_stop_d  = f_stop;
          step_d    = (f_step == 11'd0) ? 11'd1 : f_step;
          reload_d  = dwell_reload(dwell);
          mode_d    = (mode == 2'b11) ? MODE_SINGLE : mode;
          degen_d   = (f_start >= f_stop);
          dcnt_d    = dwell_reload(dwell);
          freq_d    = f_start;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_RUN_UP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN_UP: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!expire_s) begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end else if (degen_q) begin
          // Empty or inverted range: the single word has been shown, finish.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = sat_inc(cnt_q);
          state_d = ST_DONE;
        end else if (freq_q < f_stop_q) begin
          freq_d  = step_up(freq_q, step_q, f_stop_q);
          valid_d = 1'b1;
          dcnt_d  = reload_q;
        end else begin
          // Top of the sweep reached and held for its dwell.
          case (mode_q)
            MODE_REPEAT: begin
              freq_d  = f_start_q;
              valid_d = 1'b1;
              dcnt_d  = reload_q;
              cnt_d   = sat_inc(cnt_q);
            end
            MODE_TRI: begin
              freq_d  = step_down(freq_q, step_q, f_start_q);
              valid_d = 1'b1;
              dcnt_d  = reload_q;
              state_d = ST_RUN_DOWN;
            end
            default: begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              cnt_d   = sat_inc(cnt_q);
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_RUN_DOWN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!expire_s) begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end else if (freq_q > f_start_q) begin
          freq_d  = step_down(freq_q, step_q, f_start_q);
          valid_d = 1'b1;
          dcnt_d  = reload_q;
        end else begin
          // Bottom reached: one triangle period is complete, head back up.
          freq_d  = step_up(f_start_q, step_q, f_stop_q);
          valid_d = 1'b1;
          dcnt_d  = reload_q;
          cnt_d   = sat_inc(cnt_q);
          state_d = ST_RUN_UP;
        end
      end

      ST_DONE: begin
        // One-cycle completion pulse; abort here lands in IDLE just the same.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to a quiet IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      f_start_q <= 11'd0;
      f_stop_q  <= 11'd0;
      step_q    <= 11'd0;
      reload_q  <= {DWELL_W{1'b0}};
      mode_q    <= 2'b00;
      degen_q   <= 1'b0;
      dcnt_q    <= {DWELL_W{1'b0}};
      freq_q    <= 11'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      step_q    <= step_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      degen_q   <= degen_d;
      dcnt_q    <= dcnt_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_cnt  = cnt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. A list-based model turns each
// configuration into the sequence of words a sweep should visit, then
// expands it into expected per-cycle outputs.
module tb_dds_sweep_ctrl;

  localparam int DWELL_W = 16;
  localparam int CNT_W   = 8;
  localparam int CMAX    = 255;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [10:0]        f_start;
  logic [10:0]        f_stop;
  logic [10:0]        f_step;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         mode;
  logic [10:0]        freq_out;
  logic               freq_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sweep_cnt;

  int total = 0;
  int bad   = 0;
  int last_f = 0;

  int exp_f[$];
  int exp_v[$];
  int exp_b[$];
  int exp_d[$];
  int exp_c[$];
  bit trunc;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .dwell(dwell), .mode(mode),
    .freq_out(freq_out), .freq_valid(freq_valid), .busy(busy),
    .done(done), .sweep_cnt(sweep_cnt)
  );

  task automatic push_cyc(input int f, input int v, input int b, input int d, input int c);
    exp_f.push_back(f);
    exp_v.push_back(v);
    exp_b.push_back(b);
    exp_d.push_back(d);
    exp_c.push_back(c);
  endtask

  // Expected per-cycle outputs from cycle 1 after start, at most maxc run cycles.
  task automatic build_model(input int fs, input int fe, input int st, input int dw,
                             input int md, input int maxc);
    int d, s, mdn, r, c;
    int up[$];
    int dn[$];
    int wf[$];
    int wc[$];
    bit finite;
    exp_f.delete(); exp_v.delete(); exp_b.delete(); exp_d.delete(); exp_c.delete();
    trunc  = 1'b0;
    finite = 1'b1;
    d   = (dw == 0) ? 1 : dw;
    s   = (st == 0) ? 1 : st;
    mdn = (md == 3) ? 0 : md;
    if (fs >= fe) begin
      wf.push_back(fs); wc.push_back(0);
    end else begin
      r = fs; up.push_back(r);
      while (r < fe) begin r = (r + s >= fe) ? fe : r + s; up.push_back(r); end
      r = fe;
      while (r > fs) begin r = (r - s <= fs) ? fs : r - s; dn.push_back(r); end
      if (mdn == 0) begin
        foreach (up[k]) begin wf.push_back(up[k]); wc.push_back(0); end
      end else if (mdn == 1) begin
        finite = 1'b0;
        r = 0;
        while (wf.size() * d <= maxc) begin
          c = (r > CMAX) ? CMAX : r;
          foreach (up[k]) begin wf.push_back(up[k]); wc.push_back(c); end
          r++;
        end
      end else begin
        finite = 1'b0;
        foreach (up[k]) begin wf.push_back(up[k]); wc.push_back(0); end
        foreach (dn[k]) begin wf.push_back(dn[k]); wc.push_back(0); end
        r = 1;
        while (wf.size() * d <= maxc) begin
          c = (r > CMAX) ? CMAX : r;
          for (int k = 1; k < up.size(); k++) begin wf.push_back(up[k]); wc.push_back(c); end
          foreach (dn[k]) begin wf.push_back(dn[k]); wc.push_back(c); end
          r++;
        end
      end
    end
    foreach (wf[k]) begin
      for (int j = 0; j < d; j++) begin
        if (exp_f.size() >= maxc) trunc = 1'b1;
        else push_cyc(wf[k], (j == 0) ? 1 : 0, 1, 0, wc[k]);
      end
    end
    if (!trunc && finite) begin
      c = (wc[wc.size()-1] >= CMAX) ? CMAX : wc[wc.size()-1] + 1;
      push_cyc(wf[wf.size()-1], 0, 0, 1, c);
      push_cyc(wf[wf.size()-1], 0, 0, 0, c);
    end else begin
      trunc = 1'b1;
    end
  endtask

  // Start one sweep, compare every cycle, and abort it if the model was cut short.
  task automatic run_cfg(input string name, input int fs, input int fe, input int st,
                         input int dw, input int md, input int maxc, input bit scramble);
    int n;
    build_model(fs, fe, st, dw, md, maxc);
    n = exp_f.size();
    f_start = 11'(fs); f_stop = 11'(fe); f_step = 11'(st);
    dwell = DWELL_W'(dw); mode = 2'(md);
    start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      total++;
      if (freq_out !== 11'(exp_f[i]) || freq_valid !== 1'(exp_v[i]) || busy !== 1'(exp_b[i])
          || done !== 1'(exp_d[i]) || sweep_cnt !== CNT_W'(exp_c[i])) begin
        bad++;
        $display("FAIL %s cyc=%0d got f=%0d v=%0b b=%0b d=%0b c=%0d want f=%0d v=%0d b=%0d d=%0d c=%0d",
                 name, i + 1, freq_out, freq_valid, busy, done, sweep_cnt,
                 exp_f[i], exp_v[i], exp_b[i], exp_d[i], exp_c[i]);
      end
      if (scramble) begin
        f_start = 11'($urandom); f_stop = 11'($urandom); f_step = 11'($urandom);
        dwell = DWELL_W'($urandom_range(0, 7)); mode = 2'($urandom);
        start = (exp_b[i] == 1) ? 1'($urandom) : 1'b0;
      end
      if (i == n - 1 && trunc) abort = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    last_f = exp_f[n-1];
    if (trunc) begin
      total++;
      if (busy !== 1'b0 || freq_valid !== 1'b0 || done !== 1'b0
          || freq_out !== 11'(exp_f[n-1]) || sweep_cnt !== CNT_W'(exp_c[n-1])) begin
        bad++;
        $display("FAIL %s_abort got f=%0d v=%0b b=%0b d=%0b c=%0d want f=%0d v=0 b=0 d=0 c=%0d",
                 name, freq_out, freq_valid, busy, done, sweep_cnt, exp_f[n-1], exp_c[n-1]);
      end
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (freq_out !== 11'd0 || freq_valid !== 1'b0 || busy !== 1'b0
        || done !== 1'b0 || sweep_cnt !== 8'd0) begin
      bad++;
      $display("FAIL %s got f=%0d v=%0b b=%0b d=%0b c=%0d want all zero",
               name, freq_out, freq_valid, busy, done, sweep_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b1; abort = 1'b0;
    f_start = 11'd5; f_stop = 11'd50; f_step = 11'd5; dwell = 16'd2; mode = 2'b00;
    repeat (3) @(negedge clk);
    check_zero("reset_with_start");
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    check_zero("reset_release_idle");
  endtask

  task automatic test_single();
    run_cfg("single", 8, 32, 8, 3, 0, 100, 1'b0);
    run_cfg("mode3_single", 100, 130, 10, 2, 3, 100, 1'b1);
  endtask

  task automatic test_clamp_zero();
    run_cfg("clamp_dwell0", 10, 25, 8, 0, 0, 100, 1'b0);
    run_cfg("step0", 10, 15, 0, 1, 0, 100, 1'b0);
    run_cfg("top_no_wrap", 2000, 2047, 2047, 2, 0, 50, 1'b0);
  endtask

  task automatic test_triangle_repeat();
    run_cfg("triangle", 0, 16, 8, 1, 2, 20, 1'b0);
    run_cfg("repeat", 0, 16, 8, 1, 1, 20, 1'b0);
    run_cfg("tri_wide", 5, 2047, 2000, 1, 2, 30, 1'b1);
    run_cfg("cnt_saturate", 0, 1, 1, 1, 1, 600, 1'b0);
  endtask

  task automatic test_abort();
    run_cfg("abort_c5", 8, 32, 8, 3, 0, 5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || freq_out !== 11'd16) begin
        bad++;
        $display("FAIL abort_quiet got f=%0d b=%0b d=%0b want f=16 b=0 d=0", freq_out, busy, done);
      end
      @(negedge clk);
    end
    f_start = 11'd1; f_stop = 11'd9; f_step = 11'd1; dwell = 16'd1; mode = 2'b01;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy !== 1'b0 || freq_valid !== 1'b0 || freq_out !== 11'(last_f)) begin
        bad++;
        $display("FAIL start_with_abort got f=%0d v=%0b b=%0b want f=%0d v=0 b=0",
                 freq_out, freq_valid, busy, last_f);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_degenerate();
    run_cfg("degen_eq", 40, 40, 5, 4, 1, 50, 1'b1);
    run_cfg("degen_gt", 900, 100, 7, 2, 2, 50, 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    f_start = 11'd8; f_stop = 11'd32; f_step = 11'd8; dwell = 16'd3; mode = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_sweep");
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_idle");
    run_cfg("restart_after_reset", 8, 32, 8, 3, 0, 100, 1'b0);
  endtask

  task automatic test_random();
    int fs, fe, st, dw, md;
    for (int it = 0; it < 30; it++) begin
      fs = $urandom_range(0, 2047);
      fe = $urandom_range(0, 2047);
      if (it % 3 != 0 && fe <= fs) begin
        fe = fs + $urandom_range(1, 60);
        if (fe > 2047) fe = 2047;
      end
      st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2047 >> $urandom_range(0, 10));
      dw = $urandom_range(0, 4);
      md = $urandom_range(0, 3);
      run_cfg("random", fs, fe, st, dw, md, 60, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp_zero();
    test_triangle_repeat();
    test_abort();
    test_degenerate();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
